reg_file: RTL and testbench

- Register file for the 16-bit pipelined CPU.
- Consumes the writeback address from the writeback-address mux, plus writeback data and enable from the MEM/WB pipeline register.
- Supplies the ID stage with two operands, read combinationally.
- Holds general registers R0–R7 and special registers SP, IH, RA, T. Writes commit on the clock edge; same-cycle writes are bypassed to the read ports so the ID stage never sees stale data.

---
 rtl/reg_file_pkg.sv | 35 +++
 rtl/reg_bypass.sv | 54 +++++
 rtl/reg_file.sv | 109 ++++++++++
 tb/tb_reg_file.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// ----------------------------------------------------------------------------
// reg_file_pkg
// Shared definitions for the register file of the 16-bit pipelined CPU:
// bus widths, the register address map and the reset value of SP.
// ----------------------------------------------------------------------------
package reg_file_pkg;

    // Widths of the shared register-address bus and the data bus.
    localparam int REG_ADDR_BUS = 4;
    localparam int DATA_BUS     = 16;

    // Number of implemented registers (R0-R7, SP, IH, RA, T).
    localparam int NUM_REGS = 12;

    // Register address map. Addresses 12-14 are reserved.
    localparam logic [REG_ADDR_BUS-1:0] REG_R0 = 4'd0;
    localparam logic [REG_ADDR_BUS-1:0] REG_R1 = 4'd1;
    localparam logic [REG_ADDR_BUS-1:0] REG_R2 = 4'd2;
    localparam logic [REG_ADDR_BUS-1:0] REG_R3 = 4'd3;
    localparam logic [REG_ADDR_BUS-1:0] REG_R4 = 4'd4;
    localparam logic [REG_ADDR_BUS-1:0] REG_R5 = 4'd5;
    localparam logic [REG_ADDR_BUS-1:0] REG_R6 = 4'd6;
    localparam logic [REG_ADDR_BUS-1:0] REG_R7 = 4'd7;
    localparam logic [REG_ADDR_BUS-1:0] REG_SP = 4'd8;
    localparam logic [REG_ADDR_BUS-1:0] REG_IH = 4'd9;
    localparam logic [REG_ADDR_BUS-1:0] REG_RA = 4'd10;
    localparam logic [REG_ADDR_BUS-1:0] REG_T  = 4'd11;

    // "No register" marker driven by the writeback-address mux.
    localparam logic [REG_ADDR_BUS-1:0] EMPTY_ADDR = 4'hF;

    // Reset value of the stack pointer.
    localparam logic [DATA_BUS-1:0] SP_INIT = 16'hBF10;

endpackage : reg_file_pkg

// File: rtl/reg_bypass.sv
// ----------------------------------------------------------------------------
// reg_bypass
// One read port of the register file. Selects between the stored register
// value and the in-flight writeback data, and forces reserved / EMPTY
// addresses to read as zero. Purely combinational.
//
// Ports:
//   rst         in   synchronous reset of the register file (suppresses bypass)
//   wb_en       in   writeback enable
//   wb_addr     in   writeback destination address
//   wb_data     in   writeback value
//   rd_addr     in   read address of this port
//   stored_data in   value currently held in the register at rd_addr
//   rd_data     out  value presented to the ID stage
// ----------------------------------------------------------------------------
module reg_bypass
    import reg_file_pkg::*;
#(
    parameter int DATA_W    = DATA_BUS,
    parameter int ADDR_W    = REG_ADDR_BUS,
    parameter bit BYPASS_EN = 1'b1
) (
    input  logic              rst,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] stored_data,
    output logic [DATA_W-1:0] rd_data
);

    logic rd_valid;
    logic wb_valid;
    logic hit;

    assign rd_valid = (rd_addr < ADDR_W'(NUM_REGS));
    assign wb_valid = (wb_addr < ADDR_W'(NUM_REGS));

    // A write that reset will discard must not be forwarded either, so the
    // ID stage sees exactly what the storage will hold.
    assign hit = BYPASS_EN && !rst && wb_en && wb_valid && (rd_addr == wb_addr);

    // NOTE: every output of a combinational block gets a default first, so
    // no path through the block leaves it unassigned and infers a latch.
    always_comb begin
        rd_data = '0;
        if (hit) begin
            rd_data = wb_data;
        end else if (rd_valid) begin
            rd_data = stored_data;
        end
    end

endmodule : reg_bypass

// File: rtl/reg_file.sv
// ----------------------------------------------------------------------------
// reg_file
// Register file of the 16-bit pipelined CPU: R0-R7 plus SP, IH, RA and T.
// Writes commit on the rising edge; two combinational read ports forward a
// same-cycle write so the ID stage never sees stale data.
//
// Ports:
//   clk      in   system clock
//   rst      in   synchronous, active-high reset
//   wb_en    in   writeback enable (MEM/WB)
//   wb_addr  in   writeback destination (writeback-address mux)
//   wb_data  in   writeback value (MEM/WB)
//   ra_addr  in   read port A address
//   rb_addr  in   read port B address
//   ra_data  out  read port A value (combinational)
//   rb_data  out  read port B value (combinational)
//   sp_out   out  stored SP
//   ih_out   out  stored IH (interrupt mask)
//   t_out    out  stored T (branch-on-T)
// ----------------------------------------------------------------------------
module reg_file
    import reg_file_pkg::*;
#(
    parameter int                 DATA_W    = DATA_BUS,
    parameter int                 ADDR_W    = REG_ADDR_BUS,
    parameter logic [DATA_W-1:0]  SP_INIT   = reg_file_pkg::SP_INIT,
    parameter bit                 BYPASS_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic [ADDR_W-1:0] ra_addr,
    input  logic [ADDR_W-1:0] rb_addr,
    output logic [DATA_W-1:0] ra_data,
    output logic [DATA_W-1:0] rb_data,
    output logic [DATA_W-1:0] sp_out,
    output logic [DATA_W-1:0] ih_out,
    output logic [DATA_W-1:0] t_out
);

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [DATA_W-1:0] ra_stored;
    logic [DATA_W-1:0] rb_stored;

    // NOTE: the storage array is reset register by register because the
    // architectural state (SP in particular) must be defined after reset;
    // state is updated with non-blocking assignments so every register
    // samples its inputs from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            regs[REG_SP] <= SP_INIT;
        end else if (wb_en && (wb_addr < ADDR_W'(NUM_REGS))) begin
            regs[wb_addr] <= wb_data;
        end
    end

    // Stored value lookup; addresses past the last register have no storage
    // and are zeroed here as well as in the bypass stage.
    always_comb begin
        ra_stored = '0;
        rb_stored = '0;
        if (ra_addr < ADDR_W'(NUM_REGS)) begin
            ra_stored = regs[ra_addr];
        end
        if (rb_addr < ADDR_W'(NUM_REGS)) begin
            rb_stored = regs[rb_addr];
        end
    end

    reg_bypass #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .BYPASS_EN (BYPASS_EN)
    ) u_bypass_a (
        .rst         (rst),
        .wb_en       (wb_en),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .rd_addr     (ra_addr),
        .stored_data (ra_stored),
        .rd_data     (ra_data)
    );

    reg_bypass #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .BYPASS_EN (BYPASS_EN)
    ) u_bypass_b (
        .rst         (rst),
        .wb_en       (wb_en),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .rd_addr     (rb_addr),
        .stored_data (rb_stored),
        .rd_data     (rb_data)
    );

    // Special registers feed control logic directly from storage; they are
    // deliberately not forwarded.
    assign sp_out = regs[REG_SP];
    assign ih_out = regs[REG_IH];
    assign t_out  = regs[REG_T];

endmodule : reg_file

// File: tb/tb_reg_file.sv
// ----------------------------------------------------------------------------
// tb_reg_file
// Self-checking bench for reg_file (BYPASS_EN=1). A behavioural model keeps
// the twelve architectural registers in a plain array and derives read
// results from the address-map and forwarding rules.
// ----------------------------------------------------------------------------
module tb_reg_file;

    logic        clk;
    logic        rst;
    logic        wb_en;
    logic [3:0]  wb_addr;
    logic [15:0] wb_data;
    logic [3:0]  ra_addr;
    logic [3:0]  rb_addr;
    logic [15:0] ra_data;
    logic [15:0] rb_data;
    logic [15:0] sp_out;
    logic [15:0] ih_out;
    logic [15:0] t_out;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] model [12];

    reg_file dut (
        .clk     (clk),
        .rst     (rst),
        .wb_en   (wb_en),
        .wb_addr (wb_addr),
        .wb_data (wb_data),
        .ra_addr (ra_addr),
        .rb_addr (rb_addr),
        .ra_data (ra_data),
        .rb_data (rb_data),
        .sp_out  (sp_out),
        .ih_out  (ih_out),
        .t_out   (t_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected read value for an address given the current inputs.
    function automatic logic [15:0] model_read(input logic [3:0] addr);
        int a;
        a = int'(addr);
        if (a > 11) return 16'h0000;
        if (!rst && wb_en && (int'(wb_addr) <= 11) && addr == wb_addr) return wb_data;
        return model[a];
    endfunction

    // Advance one clock: commit the model's view of the edge, then wait
    // until just after the DUT edge.
    task automatic tick();
        if (rst) begin
            for (int i = 0; i < 12; i++) model[i] = 16'h0000;
            model[8] = 16'hBF10;
        end else if (wb_en && int'(wb_addr) <= 11) begin
            model[int'(wb_addr)] = wb_data;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; wb_en = 1'b0; wb_addr = 4'hF; wb_data = 16'h0;
        ra_addr = 4'd0; rb_addr = 4'd0;
        tick();
        rst = 1'b0; ra_addr = 4'd8; rb_addr = 4'd3;
        #1;
        n_checks++; if (ra_data !== 16'hBF10) begin n_fail++; $display("FAIL reset_ra got %h expected %h", ra_data, 16'hBF10); end
        n_checks++; if (rb_data !== 16'h0000) begin n_fail++; $display("FAIL reset_rb got %h expected %h", rb_data, 16'h0000); end
        n_checks++; if (sp_out  !== 16'hBF10) begin n_fail++; $display("FAIL reset_sp got %h expected %h", sp_out, 16'hBF10); end
        n_checks++; if (ih_out  !== 16'h0000) begin n_fail++; $display("FAIL reset_ih got %h expected %h", ih_out, 16'h0000); end
        n_checks++; if (t_out   !== 16'h0000) begin n_fail++; $display("FAIL reset_t got %h expected %h", t_out, 16'h0000); end
    endtask

    task automatic test_write_read();
        wb_en = 1'b1; wb_addr = 4'd2; wb_data = 16'h1234;
        tick();
        wb_en = 1'b0; ra_addr = 4'd2;
        #1;
        n_checks++; if (ra_data !== 16'h1234) begin n_fail++; $display("FAIL write_read got %h expected %h", ra_data, 16'h1234); end
    endtask

    task automatic test_bypass();
        wb_en = 1'b1; wb_addr = 4'd5; wb_data = 16'hA5A5; ra_addr = 4'd5; rb_addr = 4'd5;
        #1;
        n_checks++; if (ra_data !== 16'hA5A5) begin n_fail++; $display("FAIL bypass_ra got %h expected %h", ra_data, 16'hA5A5); end
        n_checks++; if (rb_data !== 16'hA5A5) begin n_fail++; $display("FAIL bypass_rb got %h expected %h", rb_data, 16'hA5A5); end
        tick();
        wb_en = 1'b0; rb_addr = 4'd2;
        #1;
        n_checks++; if (ra_data !== 16'hA5A5) begin n_fail++; $display("FAIL bypass_stored got %h expected %h", ra_data, 16'hA5A5); end
        n_checks++; if (rb_data !== 16'h1234) begin n_fail++; $display("FAIL bypass_other_port got %h expected %h", rb_data, 16'h1234); end
    endtask

    task automatic test_empty_reserved();
        wb_en = 1'b1; wb_addr = 4'd15; wb_data = 16'hFFFF; ra_addr = 4'd15; rb_addr = 4'd13;
        #1;
        n_checks++; if (ra_data !== 16'h0000) begin n_fail++; $display("FAIL empty_no_bypass got %h expected %h", ra_data, 16'h0000); end
        tick();
        wb_addr = 4'd13; wb_data = 16'h7777;
        #1;
        n_checks++; if (rb_data !== 16'h0000) begin n_fail++; $display("FAIL reserved_no_bypass got %h expected %h", rb_data, 16'h0000); end
        n_checks++; if (ra_data !== 16'h0000) begin n_fail++; $display("FAIL empty_read got %h expected %h", ra_data, 16'h0000); end
        tick();
        wb_en = 1'b0;
        for (int a = 0; a < 16; a++) begin
            ra_addr = 4'(a);
            #1;
            n_checks++;
            if (ra_data !== model_read(4'(a))) begin
                n_fail++;
                $display("FAIL scan_addr_%0d got %h expected %h", a, ra_data, model_read(4'(a)));
            end
        end
        n_checks++; if (sp_out !== 16'hBF10) begin n_fail++; $display("FAIL empty_sp_kept got %h expected %h", sp_out, 16'hBF10); end
    endtask

    task automatic test_special_outputs();
        wb_en = 1'b1; wb_addr = 4'd11; wb_data = 16'h0001;
        #1;
        n_checks++; if (t_out !== 16'h0000) begin n_fail++; $display("FAIL t_early got %h expected %h", t_out, 16'h0000); end
        tick();
        wb_addr = 4'd9; wb_data = 16'h8000;
        #1;
        n_checks++; if (t_out  !== 16'h0001) begin n_fail++; $display("FAIL t_after got %h expected %h", t_out, 16'h0001); end
        n_checks++; if (ih_out !== 16'h0000) begin n_fail++; $display("FAIL ih_early got %h expected %h", ih_out, 16'h0000); end
        tick();
        wb_en = 1'b0;
        #1;
        n_checks++; if (ih_out !== 16'h8000) begin n_fail++; $display("FAIL ih_after got %h expected %h", ih_out, 16'h8000); end
    endtask

    task automatic test_reset_vs_write();
        wb_en = 1'b1; wb_addr = 4'd8; wb_data = 16'h1111;
        tick();
        rst = 1'b1; wb_en = 1'b1; wb_addr = 4'd8; wb_data = 16'h0000; ra_addr = 4'd8;
        #1;
        n_checks++; if (ra_data !== 16'h1111) begin n_fail++; $display("FAIL rst_no_bypass got %h expected %h", ra_data, 16'h1111); end
        tick();
        rst = 1'b0; wb_en = 1'b0;
        #1;
        n_checks++; if (sp_out  !== 16'hBF10) begin n_fail++; $display("FAIL rst_priority_sp got %h expected %h", sp_out, 16'hBF10); end
        n_checks++; if (ra_data !== 16'hBF10) begin n_fail++; $display("FAIL rst_priority_ra got %h expected %h", ra_data, 16'hBF10); end
        n_checks++; if (t_out   !== 16'h0000) begin n_fail++; $display("FAIL rst_clears_t got %h expected %h", t_out, 16'h0000); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rst     = ($urandom_range(0, 29) == 0);
            wb_en   = 1'($urandom_range(0, 1));
            wb_addr = 4'($urandom_range(0, 15));
            wb_data = 16'($urandom);
            ra_addr = ($urandom_range(0, 2) == 0) ? wb_addr : 4'($urandom_range(0, 15));
            rb_addr = 4'($urandom_range(0, 15));
            #1;
            n_checks++; if (ra_data !== model_read(ra_addr)) begin n_fail++; $display("FAIL rand_ra cyc %0d addr %0d got %h expected %h", c, ra_addr, ra_data, model_read(ra_addr)); end
            n_checks++; if (rb_data !== model_read(rb_addr)) begin n_fail++; $display("FAIL rand_rb cyc %0d addr %0d got %h expected %h", c, rb_addr, rb_data, model_read(rb_addr)); end
            n_checks++; if (sp_out !== model[8])  begin n_fail++; $display("FAIL rand_sp cyc %0d got %h expected %h", c, sp_out, model[8]); end
            n_checks++; if (ih_out !== model[9])  begin n_fail++; $display("FAIL rand_ih cyc %0d got %h expected %h", c, ih_out, model[9]); end
            n_checks++; if (t_out  !== model[11]) begin n_fail++; $display("FAIL rand_t cyc %0d got %h expected %h", c, t_out, model[11]); end
            tick();
        end
        rst = 1'b0; wb_en = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 12; i++) model[i] = 16'h0000;
        rst = 1'b1; wb_en = 1'b0; wb_addr = 4'hF; wb_data = 16'h0;
        ra_addr = 4'd0; rb_addr = 4'd0;
        @(negedge clk);
        test_reset();
        test_write_read();
        test_bypass();
        test_empty_reserved();
        test_special_outputs();
        test_reset_vs_write();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_reg_file
